// File: rtl/nif_pkg.sv
// -----------------------------------------------------------------------------
// nif_pkg
// Shared constants and helpers for the network interface FIFO slice.
//   NIF_FLIT_W     default word width (flit + sideband)
//   NIF_FIFO_DEPTH default FIFO capacity in words
//   NIF_PAR_MAX_W  widest word the parity helper accepts (zero-extended input)
//   nif_clog2()    ceiling log2, usable in parameter expressions
//   nif_parity()   even-parity bit of a word (XOR reduction)
// -----------------------------------------------------------------------------
package nif_pkg;

  localparam int NIF_FLIT_W     = 72;
  localparam int NIF_FIFO_DEPTH = 256;
  localparam int NIF_PAR_MAX_W  = 1024;

  // Number of address bits needed to index 'value' entries.
  function automatic int nif_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Even parity: storing this bit alongside the word makes the total XOR zero.
  // Callers zero-extend narrower words, which leaves the parity unchanged.
  function automatic logic nif_parity(input logic [NIF_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/nif_sdp_ram.sv
// -----------------------------------------------------------------------------
// nif_sdp_ram
// Simple dual-port RAM, one clock. Port a writes, port b reads with a
// registered output (one cycle latency). The array has no reset so it maps
// onto block RAM.
// Ports:
//   clk       clock, rising edge
//   i_a_we    write enable
//   i_a_addr  write address
//   i_a_data  write data
//   i_b_re    read enable; o_b_data holds its value when low
//   i_b_addr  read address
//   o_b_data  read data, valid the cycle after i_b_re
// -----------------------------------------------------------------------------
module nif_sdp_ram #(
  parameter int W  = 72,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [W-1:0]  i_a_data,
  input  logic          i_b_re,
  input  logic [AW-1:0] i_b_addr,
  output logic [W-1:0]  o_b_data
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_b_data;

  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_data;
    end
    if (i_b_re) begin
      r_b_data <= r_mem[i_b_addr];
    end
  end

  assign o_b_data = r_b_data;

endmodule

// File: rtl/nif_sync_fifo.sv
// -----------------------------------------------------------------------------
// nif_sync_fifo
// Single-clock FIFO between the packet parser and the NIF transmit/receive
// engines. Storage is an nif_sdp_ram; reads are prefetched through a RAM
// output stage into a first-word-fall-through output register, so the
// consumer sees registered data and back-to-back pops stream without bubbles.
//
// Optional feature (macro NIF_FIFO_PARITY_EN): each RAM word carries an even
// parity bit; it is checked as the word loads into the output register and a
// mismatch sets the sticky par_err output (cleared only by reset).
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous discard of all contents
//   wr_valid      producer offers wr_data
//   wr_ready      FIFO can accept a word this cycle
//   wr_data       write word
//   rd_valid      rd_data holds the oldest word
//   rd_ready      consumer takes rd_data this cycle
//   rd_data       oldest word (registered)
//   count         words held (RAM + prefetch stage + output register)
//   almost_full   count >= AFULL_TH (registered)
//   almost_empty  count <= AEMPTY_TH (registered)
//   par_err       sticky parity error (only with NIF_FIFO_PARITY_EN)
// -----------------------------------------------------------------------------
module nif_sync_fifo
  import nif_pkg::*;
#(
  parameter int DATA_W    = NIF_FLIT_W,
  parameter int DEPTH     = NIF_FIFO_DEPTH,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16,
  parameter int CNT_W     = nif_clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty
`ifdef NIF_FIFO_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int AW = nif_clog2(DEPTH);

`ifdef NIF_FIFO_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_rdy;     // count < DEPTH, registered from next count
  logic              r_q_valid;    // RAM read output holds an unconsumed word
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_afull;
  logic              r_aempty;

  // ---------------------------------------------------------------------------
  // Datapath wires
  // ---------------------------------------------------------------------------
  logic              w_push;
  logic              w_pop;
  logic              w_q_to_out;
  logic              w_rd_en;
  logic [CNT_W-1:0]  w_ram_avail;
  logic [CNT_W-1:0]  w_count_next;
  logic [RAM_W-1:0]  w_ram_wdata;
  logic [RAM_W-1:0]  w_ram_rdata;

  assign wr_ready = r_wr_rdy & ~flush;
  assign w_push   = wr_valid & wr_ready;
  assign w_pop    = r_out_valid & rd_ready & ~flush;

  // Words written to RAM that have not yet been read out into the prefetch
  // stage or the output register.
  assign w_ram_avail = r_count - CNT_W'(r_out_valid) - CNT_W'(r_q_valid);

  // The prefetch stage moves forward whenever the output register is empty
  // or is being emptied by a pop this cycle.
  assign w_q_to_out = r_q_valid & (~r_out_valid | w_pop) & ~flush;

  // Issue a RAM read when there is unread data and the prefetch stage will be
  // free after this edge; this keeps one word in flight for bubble-free pops.
  assign w_rd_en = ~flush & (w_ram_avail != '0) & (~r_q_valid | w_q_to_out);

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

`ifdef NIF_FIFO_PARITY_EN
  assign w_ram_wdata = {nif_parity(NIF_PAR_MAX_W'(wr_data)), wr_data};
`else
  assign w_ram_wdata = wr_data;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  nif_sdp_ram #(
    .W  (RAM_W),
    .AW (AW)
  ) u_ram (
    .clk      (clk),
    .i_a_we   (w_push),
    .i_a_addr (r_wr_ptr),
    .i_a_data (w_ram_wdata),
    .i_b_re   (w_rd_en),
    .i_b_addr (r_rd_ptr),
    .o_b_data (w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, flags and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_rdy    <= 1'b0;
      r_q_valid   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
    end else begin
      r_count  <= w_count_next;
      r_wr_rdy <= (w_count_next < CNT_W'(DEPTH));
      r_afull  <= (w_count_next >= CNT_W'(AFULL_TH));
      r_aempty <= (w_count_next <= CNT_W'(AEMPTY_TH));

      if (flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_q_valid   <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_rd_en) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end

        if (w_rd_en) begin
          r_q_valid <= 1'b1;
        end else if (w_q_to_out) begin
          r_q_valid <= 1'b0;
        end

        if (w_q_to_out) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ram_rdata[DATA_W-1:0];
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef NIF_FIFO_PARITY_EN
  logic r_par_err;

  // Kept apart from the flush path: only reset clears a recorded error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_q_to_out &&
                 (nif_parity(NIF_PAR_MAX_W'(w_ram_rdata[DATA_W-1:0])) != w_ram_rdata[DATA_W])) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

  assign rd_valid     = r_out_valid;
  assign rd_data      = r_out_data;
  assign count        = r_count;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule

// File: tb/tb_nif_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_nif_sync_fifo
// Randomised and directed stimulus for nif_sync_fifo. Two instances: the
// default 256-deep FIFO and a 16-deep one for the wrap/streaming run.
// Reference model: a queue of words per instance; occupancy and flags are
// derived from the queue size. Monitors sample 1 time unit before each rising
// edge and pop/compare on every transfer.
// With NIF_FIFO_PARITY_EN defined, a corrupted parity bit is also exercised.
// -----------------------------------------------------------------------------
module tb_nif_sync_fifo;

  localparam int DW = 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 256-deep instance
  logic          flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full, almost_empty;
  logic [DW-1:0] wr_data, rd_data;
  logic [8:0]    count;
  // 16-deep instance
  logic          s_flush, s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready, s_almost_full, s_almost_empty;
  logic [DW-1:0] s_wr_data, s_rd_data;
  logic [4:0]    s_count;
`ifdef NIF_FIFO_PARITY_EN
  logic          par_err, s_par_err;
`endif

  nif_sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef NIF_FIFO_PARITY_EN
    ,
    .par_err      (par_err)
`endif
  );

  nif_sync_fifo #(
    .DATA_W    (DW),
    .DEPTH     (16),
    .AFULL_TH  (12),
    .AEMPTY_TH (4)
  ) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (s_flush),
    .wr_valid     (s_wr_valid),
    .wr_ready     (s_wr_ready),
    .wr_data      (s_wr_data),
    .rd_valid     (s_rd_valid),
    .rd_ready     (s_rd_ready),
    .rd_data      (s_rd_data),
    .count        (s_count),
    .almost_full  (s_almost_full),
    .almost_empty (s_almost_empty)
`ifdef NIF_FIFO_PARITY_EN
    ,
    .par_err      (s_par_err)
`endif
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  bit            chk_en   = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] s_exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors / scoreboards
  // ---------------------------------------------------------------------------
  int            m_sz;
  logic [DW-1:0] m_exp;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
    end else if (chk_en) begin
      m_sz = exp_q.size();
      check("count", count, m_sz);
      check("wr_ready", wr_ready, (m_sz < 256) && !flush);
      check("almost_full", almost_full, m_sz >= 240);
      check("almost_empty", almost_empty, m_sz <= 16);
      check("rd_valid_with_empty_model", rd_valid && (m_sz == 0), 1'b0);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (rd_valid && rd_ready && m_sz > 0) begin
          m_exp = exp_q.pop_front();
          check("rd_data", rd_data, m_exp);
          $display("fifo256 pop data=0x%h count=%0d", rd_data, count);
        end
        if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      end
    end
  end

  int            s_sz;
  logic [DW-1:0] s_exp;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      s_exp_q.delete();
    end else if (chk_en) begin
      s_sz = s_exp_q.size();
      check("s_count", s_count, s_sz);
      check("s_wr_ready", s_wr_ready, (s_sz < 16) && !s_flush);
      check("s_almost_full", s_almost_full, s_sz >= 12);
      check("s_almost_empty", s_almost_empty, s_sz <= 4);
      check("s_rd_valid_with_empty_model", s_rd_valid && (s_sz == 0), 1'b0);
      if (s_flush) begin
        s_exp_q.delete();
      end else begin
        if (s_rd_valid && s_rd_ready && s_sz > 0) begin
          s_exp = s_exp_q.pop_front();
          check("s_rd_data", s_rd_data, s_exp);
          $display("fifo16 pop data=0x%h count=%0d", s_rd_data, s_count);
        end
        if (s_wr_valid && s_wr_ready) s_exp_q.push_back(s_wr_data);
      end
    end
  end

  // Drain the large FIFO with rd_ready held high, bounded by a cycle budget.
  task automatic drain(input int budget, input string nm);
    int k;
    k = 0;
    rd_ready = 1'b1;
    while (count != 0 && k < budget) begin
      tick(1);
      k++;
    end
    rd_ready = 1'b0;
    check(nm, count, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_wr_ready"}, wr_ready, 1'b0);
    check({tag, "_almost_full"}, almost_full, 1'b0);
    check({tag, "_almost_empty"}, almost_empty, 1'b1);
    check({tag, "_s_count"}, s_count, 0);
    check({tag, "_s_rd_valid"}, s_rd_valid, 1'b0);
`ifdef NIF_FIFO_PARITY_EN
    check({tag, "_par_err"}, par_err, 1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst_n      = 1'b0;
    flush      = 1'b0; wr_valid   = 1'b0; wr_data   = '0; rd_ready   = 1'b0;
    s_flush    = 1'b0; s_wr_valid = 1'b0; s_wr_data = '0; s_rd_ready = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("wr_ready_before_first_edge", wr_ready, 1'b0);
    tick(1);
    check("wr_ready_after_release", wr_ready, 1'b1);
    chk_en = 1'b1;

    // Test 1: push 1..5 with rd_ready low, check fall-through latency, drain.
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(i);
      tick(1);
      if (i <= 2) check("latency_rd_valid_low", rd_valid, 1'b0);
      if (i == 3) check("latency_rd_valid_high", rd_valid, 1'b1);
    end
    wr_valid = 1'b0;
    tick(2);
    check("t1_count", count, 5);
    check("t1_rd_valid", rd_valid, 1'b1);
    check("t1_rd_data", rd_data, 1);
    drain(50, "t1_drain");
    check("t1_rd_valid_after_drain", rd_valid, 1'b0);

    // Test 2: fill to capacity, offer extra words, single pop frees space.
    wr_valid = 1'b1;
    k = 0;
    while (wr_ready && k < 400) begin
      wr_data = rand_word();
      tick(1);
      k++;
    end
    check("t2_accepted_words", k, 256);
    check("t2_count_full", count, 256);
    check("t2_almost_full", almost_full, 1'b1);
    wr_data = rand_word();
    tick(3);
    check("t2_count_after_extra", count, 256);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    #1;
    check("t2_wr_ready_same_cycle_as_pop", wr_ready, 1'b0);
    tick(1);
    rd_ready = 1'b0;
    check("t2_wr_ready_after_pop", wr_ready, 1'b1);
    check("t2_count_after_pop", count, 255);
    drain(600, "t2_drain");

    // Test 4: hold 100 words, flush together with a write, then 0xAA first.
    wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = rand_word();
      tick(1);
    end
    check("t4_count_held", count, 100);
    flush   = 1'b1;
    wr_data = DW'(8'h55);
    tick(1);
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("t4_count_after_flush", count, 0);
    check("t4_rd_valid_after_flush", rd_valid, 1'b0);
    check("t4_almost_empty_after_flush", almost_empty, 1'b1);
    wr_valid = 1'b1;
    wr_data  = DW'(8'hAA);
    tick(1);
    wr_data  = DW'(8'hBB);
    tick(1);
    wr_valid = 1'b0;
    tick(1);
    check("t4_first_word", rd_data, 8'hAA);
    check("t4_rd_valid", rd_valid, 1'b1);
    drain(20, "t4_drain");

    // Randomised traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      wr_valid = ($urandom_range(0, 99) < 65);
      rd_ready = ($urandom_range(0, 99) < 55);
      flush    = ($urandom_range(0, 599) == 0);
      wr_data  = rand_word();
      tick(1);
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    drain(600, "rand_drain");

    // Test 3: 16-deep FIFO, continuous push+pop across many pointer wraps.
    s_wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_wr_data = rand_word();
      tick(1);
    end
    s_rd_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      s_wr_data = rand_word();
      tick(1);
      check("t3_count_constant", s_count, 8);
      check("t3_no_bubble", s_rd_valid, 1'b1);
    end
    s_wr_valid = 1'b0;
    tick(12);
    s_rd_ready = 1'b0;
    check("t3_drained", s_count, 0);

    // Test 5: hold 10 words, asynchronous reset mid-cycle.
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = rand_word();
      tick(1);
    end
    wr_valid = 1'b0;
    tick(1);
    check("t5_count_held", count, 10);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_en = 1'b1;
    check("t5_wr_ready_after_release", wr_ready, 1'b1);

`ifdef NIF_FIFO_PARITY_EN
    // Test 6: corrupt the stored parity bit of a word still in RAM.
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = rand_word();
      tick(1);
    end
    wr_valid = 1'b0;
    tick(2);
    dut.u_ram.r_mem[3][DW] = ~dut.u_ram.r_mem[3][DW];
    check("t6_par_err_before", par_err, 1'b0);
    drain(20, "t6_drain");
    check("t6_par_err_set", par_err, 1'b1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t6_par_err_after_flush", par_err, 1'b1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
